// File: rtl/alu_sequencer_if.sv
// Request/response channel between the core control logic and the alu sequencer.
// The issuer uses the master modport and the sequencer uses the slave modport.
interface alu_sequencer_if #(parameter int WORD_LEN = 8);
  logic                req_valid;
  logic                req_ready;
  logic [3:0]          req_op;
  logic [WORD_LEN-1:0] req_a;
  logic [WORD_LEN-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WORD_LEN-1:0] rsp_result;
  logic                rsp_zero;
  logic                rsp_carry;
  logic                rsp_illegal;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_illegal
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_illegal
  );
endinterface

// File: rtl/alu_sequencer.sv
// Registered front end for the combinational alu: one operation in flight,
// operands registered into the alu, result and flags captured and returned.
module alu_sequencer #(
  parameter int WORD_LEN  = 8,
  parameter int COUNT_LEN = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alu_sequencer_if.slave       bus,
  output logic [WORD_LEN-1:0]  alu_a,
  output logic [WORD_LEN-1:0]  alu_b,
  output logic [3:0]           alu_op,
  input  logic [WORD_LEN-1:0]  alu_result,
  input  logic                 alu_zero,
  input  logic                 alu_carry,
  output logic [COUNT_LEN-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   op_legal;

  assign op_legal = bus.req_op inside {4'h0, 4'h1, 4'h2, 4'h8, 4'h9};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = op_legal ? EXEC : RESP;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Illegal ops leave alu_* untouched so the alu output keeps the last legal result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_a           <= '0;
      alu_b           <= '0;
      alu_op          <= '0;
      bus.rsp_result  <= '0;
      bus.rsp_zero    <= 1'b0;
      bus.rsp_carry   <= 1'b0;
      bus.rsp_illegal <= 1'b0;
      ops_done        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (op_legal) begin
              alu_a  <= bus.req_a;
              alu_b  <= bus.req_b;
              alu_op <= bus.req_op;
            end else begin
              bus.rsp_result  <= '0;
              bus.rsp_zero    <= 1'b0;
              bus.rsp_carry   <= 1'b0;
              bus.rsp_illegal <= 1'b1;
            end
          end
        end
        EXEC: begin
          bus.rsp_result  <= alu_result;
          bus.rsp_zero    <= alu_zero;
          bus.rsp_carry   <= alu_carry;
          bus.rsp_illegal <= 1'b0;
        end
        RESP: begin
          if (bus.rsp_ready) ops_done <= ops_done + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed plan items plus random ops against a
// transaction-level model (expected response, held alu operands, op count).
module tb_alu_sequencer;
  localparam int WL = 8;
  localparam int CL = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [WL-1:0] alu_a, alu_b, alu_result;
  logic [3:0]    alu_op;
  logic          alu_zero, alu_carry;
  logic [CL-1:0] ops_done;

  alu_sequencer_if #(.WORD_LEN(WL)) bus ();

  alu_sequencer #(.WORD_LEN(WL), .COUNT_LEN(CL)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model state
  int         exp_cnt = 0;
  logic [7:0] m_a = '0, m_b = '0;
  logic [3:0] m_op = '0;
  logic [3:0] p_op;
  logic [7:0] p_a, p_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left at a negedge with the sequencer idle.
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic z, input logic c,
                       input int stall, input bit pend);
    logic       legal;
    logic [7:0] er;
    logic       ez, ec, ei;
    legal = (op == 4'h0) || (op == 4'h1) || (op == 4'h2) || (op == 4'h8) || (op == 4'h9);
    er = legal ? r : 8'h00;
    ez = legal ? z : 1'b0;
    ec = legal ? c : 1'b0;
    ei = ~legal;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    alu_result    = r;
    alu_zero      = z;
    alu_carry     = c;
    bus.rsp_ready = (stall == 0);
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (legal) begin
      m_a = a; m_b = b; m_op = op;
      chk("exec_alu_a", 32'(alu_a), 32'(m_a));
      chk("exec_alu_b", 32'(alu_b), 32'(m_b));
      chk("exec_alu_op", 32'(alu_op), 32'(m_op));
      chk("exec_no_rsp", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end else begin
      chk("illegal_alu_op_held", 32'(alu_op), 32'(m_op));
    end
    chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_result", 32'(bus.rsp_result), 32'(er));
    chk("rsp_flags", {29'd0, bus.rsp_zero, bus.rsp_carry, bus.rsp_illegal}, {29'd0, ez, ec, ei});
    chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      if (pend) begin
        bus.req_valid = 1'b1;
        bus.req_op = p_op; bus.req_a = p_a; bus.req_b = p_b;
      end
      @(negedge clk);
      chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_result", 32'(bus.rsp_result), 32'(er));
      chk("stall_flags", {29'd0, bus.rsp_zero, bus.rsp_carry, bus.rsp_illegal}, {29'd0, ez, ec, ei});
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
      chk("stall_alu_a", 32'(alu_a), 32'(m_a));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % (1 << CL);
    chk("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_req_ready", 32'(bus.req_ready), 32'd1);
    chk("ops_done", 32'(ops_done), 32'(exp_cnt));
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    alu_result = '0; alu_zero = 1'b0; alu_carry = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_ops_done", 32'(ops_done), 32'd0);
    chk("rst_alu", {20'd0, alu_op, alu_a, alu_b}, 32'd0);
    chk("rst_rsp", {23'd0, bus.rsp_result, bus.rsp_illegal}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // directed plan items
    do_op(4'h1, 8'h3C, 8'h1E, 8'h5A, 1'b0, 1'b0, 0, 1'b0);
    do_op(4'h9, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 0, 1'b0);
    do_op(4'h1, 8'h11, 8'h22, 8'h33, 1'b0, 1'b0, 0, 1'b0);
    do_op(4'h5, 8'hAA, 8'h55, 8'hFF, 1'b1, 1'b1, 0, 1'b0);
    do_op(4'hA, 8'h01, 8'h02, 8'hEE, 1'b0, 1'b1, 0, 1'b0);
    chk("illegal_keeps_op1", 32'(alu_op), 32'h1);

    // backpressure with a pending request that must wait for idle
    p_op = 4'h2; p_a = 8'hC3; p_b = 8'h0F;
    do_op(4'h8, 8'h44, 8'h66, 8'h77, 1'b0, 1'b1, 10, 1'b1);
    do_op(p_op, p_a, p_b, 8'h12, 1'b0, 1'b0, 0, 1'b0);

    // random traffic
    for (int k = 0; k < 40; k++) begin
      do_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    // reset in the middle of a stalled response drops it
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = 4'h0; bus.req_a = 8'h99; bus.req_b = 8'h98;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_in_resp", 32'(bus.rsp_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_ops_done", 32'(ops_done), 32'd0);
    chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
    exp_cnt = 0; m_a = '0; m_b = '0; m_op = '0;
    @(negedge clk);
    reset_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);

    // counter wrap: 17 back-to-back legal ops on a 4-bit counter
    for (int k = 0; k < 17; k++) begin
      do_op(4'h2, 8'(k), 8'(k + 1), 8'(k * 3), 1'b0, 1'b0, 0, 1'b0);
    end
    chk("wrap_ops_done", 32'(ops_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $fatal(1);
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Registered request/response front end for the combinational alu block (a, b, op_select, result, zero, carry). It accepts one operation at a time over a valid/ready request channel and drives registered operands and opcode into the alu. It captures result and flags, then returns them over a valid/ready response channel. It is the issuing side of the alu interface and sits between the core control logic and the alu instance.

Parameters:
WORD_LEN, 8, operand and result width in bits.
COUNT_LEN, 16, width of the completed-operation counter.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  sequencer can accept a request.
req_op  input  4  alu opcode.
req_a  input  WORD_LEN  operand a.
req_b  input  WORD_LEN  operand b.
alu_a  output  WORD_LEN  registered operand to alu.a.
alu_b  output  WORD_LEN  registered operand to alu.b.
alu_op  output  4  registered opcode to alu.op_select.
alu_result  input  WORD_LEN  from alu.result.
alu_zero  input  1  from alu.zero.
alu_carry  input  1  from alu.carry.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts response.
rsp_result  output  WORD_LEN  captured result.
rsp_zero  output  1  captured zero flag.
rsp_carry  output  1  captured carry flag.
rsp_illegal  output  1  opcode was unsupported.
ops_done  output  COUNT_LEN  count of completed response handshakes.

Behaviour:
- Legal opcodes: 4'h0, 4'h1, 4'h2, 4'h8, 4'h9. All others (4'h3 to 4'h7, 4'hA to 4'hF) are illegal.
- States: IDLE, EXEC, RESP. Encoding is free. The reset state is IDLE.
- Reset (reset_n low, takes effect immediately and asynchronously): state IDLE; alu_a, alu_b, alu_op = 0; rsp_result = 0; rsp_zero, rsp_carry, rsp_illegal, rsp_valid = 0; ops_done = 0.
- req_ready = 1 only in IDLE. It is a combinational decode of state and does not depend on req_valid.
- IDLE, with req_valid=1:
  - Legal op: register req_a/req_b/req_op into alu_a/alu_b/alu_op; go to EXEC.
  - Illegal op: alu_* hold their previous values; load rsp_result=0, rsp_zero=0, rsp_carry=0, rsp_illegal=1; go to RESP.
- EXEC (exactly one cycle): the alu settles combinationally on the registered operands. On the exiting edge, capture alu_result/alu_zero/alu_carry into rsp_*; set rsp_illegal=0; go to RESP.
- RESP: rsp_valid=1. All rsp_* hold stable until the handshake (rsp_valid and rsp_ready on the same edge). On the handshake, go to IDLE and increment ops_done; ops_done wraps modulo 2^COUNT_LEN.
- Latency:
  - Legal op: request accepted at edge N; capture at edge N+1; rsp_valid high after edge N+1.
  - Illegal op: rsp_valid high after edge N.
  - Minimum period is 3 cycles per legal op (IDLE, EXEC, RESP) and 2 per illegal op.
- rsp_ready held high before a response exists has no effect. rsp_ready low stalls indefinitely in RESP.
- Requests are not accepted in EXEC or RESP. A req_valid asserted in those states must be held by the source until req_ready.
- alu_a/alu_b/alu_op hold the last legal operation after the response, so the alu output stays stable.
- Reset asserted in EXEC or RESP discards the in-flight operation: no response and no counter increment.

Test Plan:
- Bench uses an alu stub that drives alu_result, alu_zero and alu_carry directly.
- Reset: reset_n=0 mid-RESP -> next sample shows rsp_valid=0, req_ready=1, ops_done=0, alu_op=0.
- Legal op: req op=4'h1, a=8'h3C, b=8'h1E, stub drives result=8'h5A, z=0, c=0 -> alu_a=8'h3C and alu_b=8'h1E one cycle after accept; rsp_valid two edges after accept with rsp_result=8'h5A, rsp_illegal=0; ops_done=1 after handshake.
- Flag capture: op=4'h9, stub result=8'h00, z=1, c=1 -> rsp_zero=1, rsp_carry=1, rsp_result=8'h00.
- Illegal op: op=4'h5 with prior alu_op=4'h1 -> rsp_valid one edge after accept, rsp_illegal=1, rsp_result=0, alu_op stays 4'h1. Repeat with op=4'hA -> same response.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_* stable, req_ready=0, a new req_valid is ignored; rsp_ready=1 -> handshake, IDLE, pending request accepted on the next edge.
- Counter wrap: COUNT_LEN=4, 17 back-to-back legal ops with rsp_ready=1 -> ops_done=1, each op 3 cycles apart.
